// File: rtl/bird_motion_ctrl.sv
// Bird motion, game state and score controller: pops keypad events, integrates
// gravity/flap velocity once per video frame and tracks IDLE/PLAY/DEAD.
module bird_motion_ctrl #(
    parameter logic        [9:0] X_POS        = 10'd160,
    parameter logic        [8:0] Y_START      = 9'd240,
    parameter logic        [3:0] GRAVITY      = 4'd1,
    parameter logic signed [5:0] FLAP_VEL     = -6'sd8,
    parameter logic signed [5:0] VMAX         = 6'sd12,
    parameter logic        [7:0] SCORE_FRAMES = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_ready,
    input  logic [4:0] key_code,
    input  logic       collide,
    output logic       key_rdn,
    output logic [9:0] bird_x,
    output logic [8:0] bird_y,
    output logic [1:0] state,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Keypad handshake: key_ready is a level; a rising edge is one event and
    // key_rdn pulses low for the cycle after it to pop that event.
    state_t             state_q, state_d;
    logic        [8:0]  y_q, y_d;
    logic signed [5:0]  vel_q, vel_d;
    logic        [7:0]  score_q, score_d;
    logic        [7:0]  frame_q, frame_d;
    logic               pend_q, pend_d;
    logic               was_ready;
    logic               key_event, flap_key, start_key, flap_eff;
    logic signed [10:0] y_next;
    logic signed [7:0]  vel_inc;
    logic signed [5:0]  vel_new;

    assign key_event = key_ready & ~was_ready;
    assign flap_key  = key_event && (key_code == 5'h05);
    assign start_key = key_event && (key_code == 5'h0c);
    assign flap_eff  = pend_q | flap_key;

    assign y_next  = $signed({2'b00, y_q}) + $signed({{5{vel_q[5]}}, vel_q});
    assign vel_inc = $signed({{2{vel_q[5]}}, vel_q}) + $signed({4'b0000, GRAVITY});
    assign vel_new = flap_eff ? FLAP_VEL :
                     (vel_inc > $signed({{2{VMAX[5]}}, VMAX})) ? VMAX : vel_inc[5:0];

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        score_d = score_q;
        frame_d = frame_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                y_d     = Y_START;
                vel_d   = '0;
                score_d = '0;
                frame_d = '0;
                pend_d  = 1'b0;
                if (start_key) state_d = PLAY;
            end
            PLAY: begin
                if (frame_tick) begin
                    pend_d = 1'b0;
                    if (y_next < 11'sd0) begin
                        y_d   = '0;
                        vel_d = '0;
                    end else if (y_next > 11'sd479) begin
                        y_d     = 9'd479;
                        vel_d   = vel_new;
                        state_d = DEAD;
                    end else begin
                        y_d   = y_next[8:0];
                        vel_d = vel_new;
                    end
                    if (frame_q + 8'd1 == SCORE_FRAMES) begin
                        frame_d = '0;
                        if (score_q != 8'hff) score_d = score_q + 8'd1;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end else begin
                    pend_d = flap_eff;
                end
                if (collide) state_d = DEAD;
            end
            DEAD: begin
                if (start_key) begin
                    state_d = IDLE;
                    y_d     = Y_START;
                    vel_d   = '0;
                    score_d = '0;
                    frame_d = '0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= Y_START;
            vel_q     <= '0;
            score_q   <= '0;
            frame_q   <= '0;
            pend_q    <= 1'b0;
            was_ready <= 1'b0;
            key_rdn   <= 1'b1;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            vel_q     <= vel_d;
            score_q   <= score_d;
            frame_q   <= frame_d;
            pend_q    <= pend_d;
            was_ready <= key_ready;
            key_rdn   <= ~key_event;
        end
    end

    assign bird_x = X_POS;
    assign bird_y = y_q;
    assign state  = state_q;
    assign score  = score_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Bench for bird_motion_ctrl: directed scenarios plus random play, checked against
// an integer game model that follows the movement and scoring rules.
module tb_bird_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       key_ready = 1'b0;
    logic [4:0] key_code = 5'h00;
    logic       collide = 1'b0;
    logic       key_rdn;
    logic [9:0] bird_x;
    logic [8:0] bird_y;
    logic [1:0] state;
    logic [7:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference game: plain integers, state 0=idle 1=play 2=dead.
    int m_state, m_y, m_vel, m_score, m_frames;
    bit m_pend, m_was, m_rdn;

    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    bird_motion_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .key_ready(key_ready),
        .key_code(key_code), .collide(collide), .key_rdn(key_rdn), .bird_x(bird_x),
        .bird_y(bird_y), .state(state), .score(score)
    );

    task automatic model_reset();
        m_state = 0; m_y = 240; m_vel = 0; m_score = 0; m_frames = 0;
        m_pend = 0; m_was = 0; m_rdn = 1;
    endtask

    task automatic model_step();
        bit ev, flap, start, pend, dead;
        int ny, nv;
        ev    = key_ready && !m_was;
        flap  = ev && key_code == 5'h05;
        start = ev && key_code == 5'h0c;
        m_was = key_ready;
        m_rdn = !ev;
        if (rst) begin
            model_reset();
            return;
        end
        dead = 0;
        case (m_state)
            0: if (start) m_state = 1;
            1: begin
                pend = m_pend || flap;
                if (frame_tick) begin
                    ny = m_y + m_vel;
                    nv = pend ? -8 : ((m_vel + 1 > 12) ? 12 : m_vel + 1);
                    m_pend = 0;
                    if (ny < 0) begin
                        m_y = 0; m_vel = 0;
                    end else if (ny > 479) begin
                        m_y = 479; m_vel = nv; dead = 1;
                    end else begin
                        m_y = ny; m_vel = nv;
                    end
                    m_frames++;
                    if (m_frames == 64) begin
                        m_frames = 0;
                        if (m_score < 255) m_score++;
                    end
                end else begin
                    m_pend = pend;
                end
                if (collide || dead) m_state = 2;
            end
            default: if (start) begin
                m_state = 0; m_y = 240; m_vel = 0; m_score = 0; m_frames = 0; m_pend = 0;
            end
        endcase
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] code);
        key_ready = 1'b1; key_code = code;
        step();
        key_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks += 5;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        if (bird_y !== 9'd240) begin n_fail++; $display("FAIL reset_y: got %0d expected 240", bird_y); end
        if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        if (key_rdn !== 1'b1) begin n_fail++; $display("FAIL reset_rdn: got %0d expected 1", key_rdn); end
        if (bird_x !== 10'd160) begin n_fail++; $display("FAIL bird_x: got %0d expected 160", bird_x); end
    endtask

    task automatic test_start();
        key_ready = 1'b1; key_code = 5'h0c;
        step();
        n_checks += 3;
        if (key_rdn !== 1'b0) begin n_fail++; $display("FAIL start_pop: got %0d expected 0", key_rdn); end
        if (state !== 2'(m_state)) begin n_fail++; $display("FAIL start_state: got %0d expected %0d", state, m_state); end
        if (bird_y !== 9'(m_y)) begin n_fail++; $display("FAIL start_y: got %0d expected %0d", bird_y, m_y); end
        step();
        n_checks++;
        if (key_rdn !== 1'b1) begin n_fail++; $display("FAIL start_pop_once: got %0d expected 1", key_rdn); end
        key_ready = 1'b0;
        step();
    endtask

    task automatic test_fall();
        logic [8:0] e;
        exp_q.push_back(9'd240); exp_q.push_back(9'd241); exp_q.push_back(9'd243);
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (bird_y !== e || bird_y !== 9'(m_y)) begin
                n_fail++; $display("FAIL fall_y%0d: got %0d expected %0d", i, bird_y, e);
            end
            step();
        end
        // Flap arriving on the tick cycle itself must count for that tick.
        key_ready = 1'b1; key_code = 5'h05; frame_tick = 1'b1;
        step();
        key_ready = 1'b0; frame_tick = 1'b0;
        n_checks++;
        if (bird_y !== 9'(m_y)) begin n_fail++; $display("FAIL flap_tick_y: got %0d expected %0d", bird_y, m_y); end
        step();
        for (int i = 0; i < 60 && m_state == 1; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            n_checks += 2;
            if (bird_y !== 9'(m_y)) begin n_fail++; $display("FAIL glide_y%0d: got %0d expected %0d", i, bird_y, m_y); end
            if (state !== 2'(m_state)) begin n_fail++; $display("FAIL glide_state%0d: got %0d expected %0d", i, state, m_state); end
            step();
        end
        n_checks += 2;
        if (state !== 2'd2) begin n_fail++; $display("FAIL floor_state: got %0d expected 2", state); end
        if (bird_y !== 9'd479) begin n_fail++; $display("FAIL floor_y: got %0d expected 479", bird_y); end
    endtask

    task automatic test_dead_restart();
        logic [8:0] y_keep;
        y_keep = bird_y;
        press(5'h05);
        n_checks++;
        if (bird_y !== y_keep) begin n_fail++; $display("FAIL dead_flap_y: got %0d expected %0d", bird_y, y_keep); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_checks++;
        if (bird_y !== 9'(m_y)) begin n_fail++; $display("FAIL dead_tick_y: got %0d expected %0d", bird_y, m_y); end
        press(5'h0c);
        n_checks += 3;
        if (state !== 2'd0) begin n_fail++; $display("FAIL restart_state: got %0d expected 0", state); end
        if (score !== 8'd0) begin n_fail++; $display("FAIL restart_score: got %0d expected 0", score); end
        if (bird_y !== 9'd240) begin n_fail++; $display("FAIL restart_y: got %0d expected 240", bird_y); end
    endtask

    task automatic test_ignored_codes();
        key_ready = 1'b1; key_code = 5'h03;
        step();
        key_ready = 1'b0;
        n_checks += 2;
        if (key_rdn !== 1'b0) begin n_fail++; $display("FAIL other_pop: got %0d expected 0", key_rdn); end
        if (state !== 2'(m_state)) begin n_fail++; $display("FAIL other_state: got %0d expected %0d", state, m_state); end
        step();
        press(5'h05);
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL idle_flap: got %0d expected 0", state); end
    endtask

    task automatic test_ceiling();
        press(5'h0c);
        for (int i = 0; i < 40; i++) begin
            key_ready = 1'b1; key_code = 5'h05; frame_tick = 1'b1;
            step();
            key_ready = 1'b0; frame_tick = 1'b0;
            n_checks += 2;
            if (bird_y !== 9'(m_y)) begin n_fail++; $display("FAIL ceil_y%0d: got %0d expected %0d", i, bird_y, m_y); end
            if (state !== 2'd1) begin n_fail++; $display("FAIL ceil_state%0d: got %0d expected 1", i, state); end
            step();
        end
        collide = 1'b1;
        step();
        collide = 1'b0;
        n_checks++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL collide_state: got %0d expected 2", state); end
        press(5'h0c);
    endtask

    task automatic test_score_and_reset();
        press(5'h0c);
        for (int i = 0; i < 128; i++) begin
            key_ready = (m_y > 250); key_code = 5'h05; frame_tick = 1'b1;
            step();
            key_ready = 1'b0; frame_tick = 1'b0;
            step();
        end
        n_checks += 3;
        if (score !== 8'd2 || score !== 8'(m_score)) begin n_fail++; $display("FAIL score_128: got %0d expected 2", score); end
        if (state !== 2'd1) begin n_fail++; $display("FAIL score_state: got %0d expected 1", state); end
        if (bird_y !== 9'(m_y)) begin n_fail++; $display("FAIL score_y: got %0d expected %0d", bird_y, m_y); end
        rst = 1'b1; frame_tick = 1'b1; key_ready = 1'b1; key_code = 5'h05;
        step();
        rst = 1'b0; frame_tick = 1'b0; key_ready = 1'b0;
        n_checks += 4;
        if (state !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", state); end
        if (bird_y !== 9'd240) begin n_fail++; $display("FAIL midrst_y: got %0d expected 240", bird_y); end
        if (score !== 8'd0) begin n_fail++; $display("FAIL midrst_score: got %0d expected 0", score); end
        if (key_rdn !== 1'b1) begin n_fail++; $display("FAIL midrst_rdn: got %0d expected 1", key_rdn); end
        step();
    endtask

    task automatic test_random();
        int pick;
        for (int i = 0; i < 1500; i++) begin
            key_ready = ($urandom_range(0, 3) == 0);
            pick = $urandom_range(0, 4);
            key_code = (pick < 2) ? 5'h05 : (pick == 2) ? 5'h0c : 5'($urandom_range(0, 31));
            frame_tick = ($urandom_range(0, 2) == 0);
            collide = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
            n_checks += 4;
            if (bird_y !== 9'(m_y)) begin n_fail++; $display("FAIL rnd_y@%0d: got %0d expected %0d", i, bird_y, m_y); end
            if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state@%0d: got %0d expected %0d", i, state, m_state); end
            if (score !== 8'(m_score)) begin n_fail++; $display("FAIL rnd_score@%0d: got %0d expected %0d", i, score, m_score); end
            if (key_rdn !== m_rdn) begin n_fail++; $display("FAIL rnd_rdn@%0d: got %0d expected %0d", i, key_rdn, m_rdn); end
        end
        rst = 1'b0; key_ready = 1'b0; frame_tick = 1'b0; collide = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_fall();
        test_dead_restart();
        test_ignored_codes();
        test_ceiling();
        test_score_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bird_motion_ctrl.md
BIRD_MOTION_CTRL -- requirements
Module: bird_motion_ctrl

Interface
REQ-001 The block SHALL have parameter X_POS, default 10'd160: fixed horizontal bird position.
REQ-002 The block SHALL have parameter Y_START, default 9'd240: bird row after reset and in IDLE.
REQ-003 The block SHALL have parameter GRAVITY, default 4'd1: per-frame velocity increment.
REQ-004 The block SHALL have parameter FLAP_VEL, default -6'sd8: signed velocity loaded on flap.
REQ-005 The block SHALL have parameter VMAX, default 6'sd12: positive velocity saturation.
REQ-006 The block SHALL have parameter SCORE_FRAMES, default 8'd64: PLAY frames per score point.
REQ-007 The block SHALL have port clk, input, 1: system clock; all state SHALL change only on its rising edge.
REQ-008 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 The block SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-010 The block SHALL have port key_ready, input, 1: keypad has an event available (level).
REQ-011 The block SHALL have port key_code, input, 5: keypad code, valid while key_ready=1.
REQ-012 The block SHALL have port collide, input, 1: pipe/bird overlap from the renderer (level).
REQ-013 The block SHALL have port key_rdn, output, 1: active-low keypad pop strobe.
REQ-014 The block SHALL have port bird_x, output, 10: always equal to X_POS.
REQ-015 The block SHALL have port bird_y, output, 9: bird row, top edge = 0.
REQ-016 The block SHALL have port state, output, 2: IDLE=0, PLAY=1, DEAD=2; 3 unused.
REQ-017 The block SHALL have port score, output, 8: score value.

Function
REQ-018 Key handshake: the block SHALL register key_ready as was_ready; a key event is key_ready=1 with was_ready=0.
REQ-019 On a key event, key_rdn SHALL go low for exactly the next cycle, then return high; otherwise key_rdn=1.
REQ-020 Key codes: 5'h5 = FLAP, 5'hc = START; all other codes SHALL be popped and ignored.
REQ-021 IDLE: bird_y=Y_START, vel=0, score=0; START SHALL move the block to PLAY next cycle; FLAP is ignored.
REQ-022 PLAY: a FLAP event SHALL set flap_pending; a FLAP coinciding with frame_tick SHALL count for that tick.
REQ-023 PLAY, on frame_tick: bird_y SHALL be set to y_next = bird_y + vel, using the old vel, in 11-bit signed arithmetic.
REQ-024 On the same tick, vel SHALL be set to FLAP_VEL if flap_pending, else min(vel+GRAVITY, VMAX); flap_pending SHALL clear.
REQ-025 If y_next < 0, bird_y SHALL be 0 and vel SHALL be 0 (ceiling clamp, no death).
REQ-026 If y_next > 479, bird_y SHALL be 479 and state SHALL go to DEAD on the next cycle (floor death).
REQ-027 collide=1 in any PLAY cycle SHALL move state to DEAD next cycle; collide SHALL be ignored in IDLE and DEAD.
REQ-028 Collide and frame_tick in the same cycle: the position update SHALL apply and state SHALL become DEAD.
REQ-029 Score: a frame counter SHALL count frame_ticks in PLAY; at SCORE_FRAMES it SHALL wrap to 0 and score SHALL increment, saturating at 255.
REQ-030 DEAD: bird_y, vel and score SHALL be frozen; START SHALL go to IDLE (score cleared); FLAP is ignored.
REQ-031 Keypad events SHALL be popped in every state, including the cycle of a state change.
REQ-032 vel SHALL be a 6-bit signed register and SHALL never exceed VMAX.

Reset
REQ-033 rst=1 SHALL set state=IDLE, bird_y=Y_START, vel=0, score=0, frame counter=0, flap_pending=0, was_ready=0, key_rdn=1, overriding any event in that cycle, including mid-PLAY.

Verification
REQ-034 Reset then key_ready=1 with code 5'hc -> key_rdn low for one cycle only, state=1, bird_y=240.
REQ-035 PLAY, no flap, 3 frame_ticks -> bird_y 240,241,243 (vel 1,2,3); vel saturates at 12 after 12 ticks.
REQ-036 PLAY, bird_y=240, vel=3, FLAP coincident with frame_tick -> bird_y=243, vel=-8; next tick bird_y=235.
REQ-037 bird_y=5, vel=-8, frame_tick -> bird_y=0, vel=0, state stays 1; bird_y=475, vel=10, tick -> bird_y=479, then state=2.
REQ-038 collide=1 for one cycle in PLAY -> state=2 next cycle; FLAP in DEAD leaves bird_y unchanged; START -> state=0, score=0.
REQ-039 128 frame_ticks in PLAY -> score=2; rst asserted mid-PLAY -> all outputs at reset values next cycle.
